mem_stage: RTL and testbench

- Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of the writeback stage.
- Latches the execute-stage bus and waits for the data-SRAM response (data_ok) of any memory request that execute already issued.
- Aligns and sign/zero-extends load data, then hands {rf_we, rf_waddr, final_result, pc} to writeback under a valid/allowin handshake.
- Exports a forwarding/hazard zip for decode.

---
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage.sv | 116 +++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and bus bundle between execute, the memory stage, writeback and the data SRAM.
// The slave modport is the memory stage; the master modport is its surroundings.
interface mem_stage_if #(
    parameter int ES_BUS_W = 75,
    parameter int MS_BUS_W = 70
);
    logic                es_to_ms_valid;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic                ms_allowin;
    logic                ws_allowin;
    logic                ms_to_ws_valid;
    logic [MS_BUS_W-1:0] ms_to_ws_bus;
    logic [38:0]         ms_rf_zip;
    logic                ms_data_pending;
    logic                data_sram_data_ok;
    logic [31:0]         data_sram_rdata;

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_rf_zip, ms_data_pending
    );

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_rf_zip, ms_data_pending
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from execute, waits for its SRAM
// response, aligns/extends load data and forwards the result to writeback.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  ms
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        ms_valid_q, ms_valid_d;
    logic        res_from_mem_q;
    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] alu_result_q;
    logic [2:0]  mem_op_q;
    logic [31:0] pc_q;
    logic [31:0] rdata_buf_q;

    logic        es_mem_req;
    logic        data_ok;
    logic        ms_ready_go;
    logic        allowin;
    logic        accept;
    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign es_mem_req  = ms.es_to_ms_bus[74];
    assign data_ok     = ms.data_sram_data_ok;
    assign ms_ready_go = (state_q == READY) || ((state_q == WAIT) && data_ok);
    assign allowin     = ~ms_valid_q | (ms_ready_go & ms.ws_allowin);
    assign accept      = ms.es_to_ms_valid & allowin;

    always_comb begin
        state_d    = state_q;
        ms_valid_d = ms_valid_q;
        if (allowin) begin
            ms_valid_d = ms.es_to_ms_valid;
            if (!ms.es_to_ms_valid) begin
                state_d = EMPTY;
            end else if (es_mem_req) begin
                state_d = WAIT;
            end else begin
                state_d = READY;
            end
        end else if ((state_q == WAIT) && data_ok) begin
            state_d = READY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= EMPTY;
            ms_valid_q     <= 1'b0;
            res_from_mem_q <= 1'b0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            alu_result_q   <= '0;
            mem_op_q       <= '0;
            pc_q           <= '0;
            rdata_buf_q    <= '0;
        end else begin
            state_q    <= state_d;
            ms_valid_q <= ms_valid_d;
            if (accept) begin
                res_from_mem_q <= ms.es_to_ms_bus[73];
                rf_we_q        <= ms.es_to_ms_bus[72];
                rf_waddr_q     <= ms.es_to_ms_bus[71:67];
                alu_result_q   <= ms.es_to_ms_bus[66:35];
                mem_op_q       <= ms.es_to_ms_bus[34:32];
                pc_q           <= ms.es_to_ms_bus[31:0];
            end
            if ((state_q == WAIT) && data_ok) begin
                rdata_buf_q <= ms.data_sram_rdata;
            end
        end
    end

    // In the data_ok cycle the raw SRAM data bypasses the buffer so a load can leave at once.
    assign load_word = (state_q == WAIT) ? ms.data_sram_rdata : rdata_buf_q;

    always_comb begin
        case (alu_result_q[1:0])
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = alu_result_q[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        case (mem_op_q)
            3'b001:  load_result = {{24{load_byte[7]}}, load_byte};
            3'b010:  load_result = {{16{load_half[15]}}, load_half};
            3'b101:  load_result = {24'd0, load_byte};
            3'b110:  load_result = {16'd0, load_half};
            default: load_result = load_word;
        endcase
    end

    assign final_result = res_from_mem_q ? load_result : alu_result_q;

    assign ms.ms_allowin      = allowin;
    assign ms.ms_to_ws_valid  = ms_valid_q & ms_ready_go;
    assign ms.ms_to_ws_bus    = {rf_we_q, rf_waddr_q, final_result, pc_q};
    assign ms.ms_rf_zip       = {39{ms_valid_q}} & {res_from_mem_q, rf_we_q, rf_waddr_q, final_result};
    assign ms.ms_data_pending = ms_valid_q & res_from_mem_q & (state_q == WAIT) & ~data_ok;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues execute/SRAM/writeback stimulus, a
// negedge monitor compares every DUT output against a queue-based model of the held instruction.
module tb_mem_stage;
    logic clk;
    logic reset;

    mem_stage_if bus_if ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .ms    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          mem_req;
        bit          res;
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [2:0]  op;
        logic [31:0] pc;
        logic [31:0] rd;
        logic [31:0] final_res;
    } item_t;

    item_t exp_q[$];

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned spurious_seen = 0;

    // driver state
    bit          holding = 0;
    bit          acc_pending = 0;
    item_t       acc_item;
    bit          mem_busy = 0;
    int unsigned mem_cnt = 0;
    logic [31:0] mem_rd = '0;
    int unsigned cur_dly = 1;
    logic [31:0] cur_rd = '0;
    logic [31:0] pc_ctr = 32'h1c00_0000;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Load value computed with plain arithmetic on shifted/masked integers.
    function automatic logic [31:0] load_model(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * off[1])) & 32'hFFFF;
        case (op)
            3'b001:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b010:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return b;
            3'b110:  return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [74:0] pack(input bit mr, input bit rs, input bit we, input logic [4:0] wa,
                                         input logic [31:0] alu, input logic [2:0] op, input logic [31:0] pc);
        return {mr, rs, we, wa, alu, op, pc};
    endfunction

    function automatic item_t make_item(input logic [74:0] b, input logic [31:0] rd);
        item_t it;
        it.mem_req = b[74];
        it.res     = b[73];
        it.we      = b[72];
        it.waddr   = b[71:67];
        it.alu     = b[66:35];
        it.op      = b[34:32];
        it.pc      = b[31:0];
        it.rd      = rd;
        it.final_res = it.res ? load_model(it.op, it.alu[1:0], rd) : it.alu;
        return it;
    endfunction

    function automatic bit relevant(input item_t it);
        return !(it.mem_req && !it.res);
    endfunction

    function automatic logic [74:0] rand_bus();
        logic [2:0] ops [8];
        int unsigned kind;
        ops = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b011, 3'b100, 3'b111};
        kind = $urandom_range(0, 2);
        pc_ctr = pc_ctr + 32'd4;
        case (kind)
            0: return pack(1'b0, 1'b0, 1'($urandom), 5'($urandom), $urandom, 3'($urandom), pc_ctr);
            1: return pack(1'b1, 1'b1, 1'b1, 5'($urandom), $urandom, ops[$urandom_range(0, 7)], pc_ctr);
            default: return pack(1'b1, 1'b0, 1'b0, 5'($urandom), $urandom, 3'b000, pc_ctr);
        endcase
    endfunction

    task automatic step(input bit nv, input logic [74:0] nb, input bit ws, input int unsigned dly,
                        input logic [31:0] rd, input bit spur);
        @(posedge clk);
        if (acc_pending) begin
            exp_q.push_back(acc_item);
            acc_pending = 0;
        end
        #1;
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus_if.data_sram_data_ok = 1'b1;
                bus_if.data_sram_rdata   = mem_rd;
                mem_busy = 0;
            end
        end else if (spur) begin
            bus_if.data_sram_data_ok = 1'b1;
        end
        if (!holding) begin
            bus_if.es_to_ms_valid = nv;
            bus_if.es_to_ms_bus   = nb;
            cur_dly = dly;
            cur_rd  = rd;
        end
        bus_if.ws_allowin = ws;
        @(negedge clk);
        holding = 0;
        if (bus_if.es_to_ms_valid) begin
            if (bus_if.ms_allowin) begin
                acc_item = make_item(bus_if.es_to_ms_bus, cur_rd);
                acc_pending = 1;
                if (acc_item.mem_req) begin
                    mem_busy = 1;
                    mem_cnt  = cur_dly;
                    mem_rd   = cur_rd;
                end
            end else begin
                holding = 1;
            end
        end
    endtask

    task automatic idle(input int unsigned n, input bit ws);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, ws, 1, '0, 1'b0);
    endtask

    // monitor: model of the single held instruction is the head of exp_q
    bit    m_returned = 0;
    bit    m_held, m_ready, m_ok;
    item_t m_f;

    always @(negedge clk) begin
        if (reset) begin
            m_returned = 0;
        end else begin
            m_held = exp_q.size() > 0;
            if (m_held) m_f = exp_q[0];
            m_ok    = bus_if.data_sram_data_ok;
            m_ready = m_held && (!m_f.mem_req || m_returned || m_ok);
            chk("to_ws_valid", 70'(bus_if.ms_to_ws_valid), 70'(m_ready));
            chk("allowin", 70'(bus_if.ms_allowin), 70'(!m_held || (m_ready && bus_if.ws_allowin)));
            chk("data_pending", 70'(bus_if.ms_data_pending),
                70'(m_held && m_f.mem_req && m_f.res && !m_returned && !m_ok));
            if (m_held) begin
                chk("zip_hdr", 70'(bus_if.ms_rf_zip[38:32]), 70'({m_f.res, m_f.we, m_f.waddr}));
                if (m_ready && relevant(m_f)) chk("zip_result", 70'(bus_if.ms_rf_zip[31:0]), 70'(m_f.final_res));
            end else begin
                chk("zip_idle", 70'(bus_if.ms_rf_zip), 70'd0);
            end
            if (m_ok && !(m_held && m_f.mem_req && !m_returned)) begin
                spurious_seen++;
                $display("note: protocol violation, data_ok with no outstanding request at %0t", $time);
            end
            if (m_ready && bus_if.ws_allowin) begin
                chk("bus_hdr", 70'(bus_if.ms_to_ws_bus[69:64]), 70'({m_f.we, m_f.waddr}));
                chk("bus_pc", 70'(bus_if.ms_to_ws_bus[31:0]), 70'(m_f.pc));
                if (relevant(m_f)) chk("bus_result", 70'(bus_if.ms_to_ws_bus[63:32]), 70'(m_f.final_res));
                void'(exp_q.pop_front());
                m_returned = 0;
            end else if (m_held && m_f.mem_req && m_ok) begin
                m_returned = 1;
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.es_to_ms_bus      = '0;
        bus_if.ws_allowin        = 1'b0;
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = '0;
        #12;
        chk("reset_valid", 70'(bus_if.ms_to_ws_valid), 70'd0);
        chk("reset_allowin", 70'(bus_if.ms_allowin), 70'd1);
        chk("reset_zip", 70'(bus_if.ms_rf_zip), 70'd0);
        chk("reset_pending", 70'(bus_if.ms_data_pending), 70'd0);
        chk("reset_bus", 70'(bus_if.ms_to_ws_bus), 70'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ALU op
        step(1'b1, pack(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 3'b000, 32'h0000_0100), 1'b1, 1, '0, 1'b0);
        idle(3, 1'b1);
        // LD.B, off 2, data_ok on the third cycle in the stage
        step(1'b1, pack(1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_1002, 3'b001, 32'h0000_0200), 1'b1, 3,
             32'h0080_0000, 1'b0);
        idle(5, 1'b1);
        // LD.HU, off 2, data_ok while writeback stalls
        step(1'b1, pack(1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_2002, 3'b110, 32'h0000_0300), 1'b0, 1,
             32'h8001_5a5a, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);
        // back-to-back ALU ops
        for (int unsigned i = 0; i < 6; i++)
            step(1'b1, pack(1'b0, 1'b0, 1'b1, 5'(i + 1), 32'h100 + i, 3'b000, 32'h400 + 4 * i), 1'b1, 1, '0, 1'b0);
        idle(2, 1'b1);
        // store, then a spurious data_ok while empty
        step(1'b1, pack(1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0044, 3'b000, 32'h0000_0500), 1'b1, 2,
             32'hdead_beef, 1'b0);
        idle(4, 1'b1);
        step(1'b0, '0, 1'b1, 1, '0, 1'b1);
        idle(2, 1'b1);

        // reset while a load waits
        step(1'b1, pack(1'b1, 1'b1, 1'b1, 5'd11, 32'h0000_3000, 3'b000, 32'h0000_0600), 1'b1, 4,
             32'h1234_5678, 1'b0);
        step(1'b0, '0, 1'b1, 1, '0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midwait_reset_valid", 70'(bus_if.ms_to_ws_valid), 70'd0);
        chk("midwait_reset_allowin", 70'(bus_if.ms_allowin), 70'd1);
        chk("midwait_reset_zip", 70'(bus_if.ms_rf_zip), 70'd0);
        chk("midwait_reset_pending", 70'(bus_if.ms_data_pending), 70'd0);
        exp_q.delete();
        mem_busy    = 0;
        acc_pending = 0;
        holding     = 0;
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.data_sram_data_ok = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // randomized traffic
        for (int unsigned i = 0; i < 3000; i++)
            step(($urandom_range(0, 3) != 0), rand_bus(), ($urandom_range(0, 3) != 0),
                 $urandom_range(1, 4), $urandom, 1'b0);

        idle(12, 1'b1);
        chk("drained", 70'(exp_q.size()), 70'd0);
        chk("spurious_count", 70'(spurious_seen), 70'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
